// File: rtl/imem_boot_loader.sv
// Boot loader: streams a program into instruction memory from address 0,
// accumulates a checksum, and holds the core in reset until the image is complete.
module imem_boot_loader #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   length,
   input  logic              s_valid,
   input  logic [31:0]       s_data,
   output logic              s_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_reset,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [31:0]       checksum
);

   typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RUN, ERR} state_t;

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

   state_t          state;
   state_t          state_next;
   logic [ADDR_W:0] count;
   logic [ADDR_W:0] len_q;
   logic            handshake;
   logic            last_word;
   logic            cmd_window;
   logic            start_legal;
   logic            load_accept;

   assign handshake   = s_valid && s_ready;
   assign last_word   = (count == (len_q - ONE));
   assign cmd_window  = (state == IDLE) || (state == RUN) || (state == ERR);
   assign start_legal = (length != '0) && (length <= DEPTH_W);
   assign load_accept = start && cmd_window && start_legal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // IDLE, RUN and ERR all accept a new command; an illegal length always lands in ERR.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, RUN, ERR: begin
            if (start) begin
               state_next = start_legal ? LOAD : ERR;
            end
         end
         LOAD: begin
            if (handshake && last_word) begin
               state_next = DRAIN;
            end
         end
         DRAIN:   state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      s_ready = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      error   = 1'b0;
      case (state)
         LOAD: begin
            s_ready = 1'b1;
            busy    = 1'b1;
         end
         DRAIN:   busy  = 1'b1;
         RUN:     done  = 1'b1;
         ERR:     error = 1'b1;
         default: ;
      endcase
   end

   // The counter deliberately runs one past the last address; only its low bits drive imem_addr.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         core_reset <= 1'b1;
         checksum   <= '0;
         count      <= '0;
         len_q      <= '0;
      end else begin
         imem_we    <= handshake;
         core_reset <= (state_next != RUN);
         if (handshake) begin
            imem_addr  <= count[ADDR_W-1:0];
            imem_wdata <= s_data;
            count      <= count + ONE;
            checksum   <= checksum + s_data;
         end
         if (load_accept) begin
            len_q    <= length;
            count    <= '0;
            checksum <= '0;
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed and randomized program loads
// compared against a transaction-level model and a bench-side instruction memory.
module tb_imem_boot_loader;

   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W:0]   length;
   logic              s_valid;
   logic [31:0]       s_data;
   logic              s_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_reset;
   logic              busy;
   logic              done;
   logic              error;
   logic [31:0]       checksum;

   int          check_count = 0;
   int          pass_count  = 0;
   int          write_count = 0;
   logic [31:0] exp_sum     = '0;
   logic [31:0] saved_sum;
   logic [31:0] prog   [0:DEPTH-1];
   logic [31:0] tb_mem [0:DEPTH-1];

   imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .length     (length),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_reset (core_reset),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   // Bench-side instruction memory: captures every write mid-cycle.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         tb_mem[imem_addr] = imem_wdata;
         write_count++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      assert (observed === expected) pass_count++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetValues(input string where);
      checkOutput({where, "_s_ready"},    32'(s_ready),    32'd0);
      checkOutput({where, "_imem_we"},    32'(imem_we),    32'd0);
      checkOutput({where, "_imem_addr"},  32'(imem_addr),  32'd0);
      checkOutput({where, "_imem_wdata"}, imem_wdata,      32'd0);
      checkOutput({where, "_core_reset"}, 32'(core_reset), 32'd1);
      checkOutput({where, "_busy"},       32'(busy),       32'd0);
      checkOutput({where, "_done"},       32'(done),       32'd0);
      checkOutput({where, "_error"},      32'(error),      32'd0);
      checkOutput({where, "_checksum"},   checksum,        32'd0);
   endtask

   // One complete load of prog[0..len-1] with random idle gaps of min_gap..max_gap cycles.
   task automatic applyStimulus(input int len, input int min_gap, input int max_gap, input bit hold_valid);
      write_count = 0;
      exp_sum     = '0;
      for (int k = 0; k < DEPTH; k++) tb_mem[k] = 'x;
      start   = 1'b1;
      length  = 7'(len);
      s_valid = 1'b0;
      step();
      start = 1'b0;
      checkOutput("start_s_ready",    32'(s_ready),    32'd1);
      checkOutput("start_busy",       32'(busy),       32'd1);
      checkOutput("start_error",      32'(error),      32'd0);
      checkOutput("start_done",       32'(done),       32'd0);
      checkOutput("start_core_reset", 32'(core_reset), 32'd1);
      checkOutput("start_checksum",   checksum,        32'd0);
      for (int i = 0; i < len; i++) begin
         int gap;
         gap = int'($urandom_range(max_gap, min_gap));
         for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            step();
            checkOutput("gap_imem_we", 32'(imem_we), 32'd0);
            checkOutput("gap_s_ready", 32'(s_ready), 32'd1);
         end
         s_valid = 1'b1;
         s_data  = prog[i];
         step();
         exp_sum = exp_sum + prog[i];
         checkOutput("write_we",       32'(imem_we),   32'd1);
         checkOutput("write_addr",     32'(imem_addr), 32'(i));
         checkOutput("write_data",     imem_wdata,     prog[i]);
         checkOutput("write_checksum", checksum,       exp_sum);
         if (i < len - 1) begin
            checkOutput("mid_s_ready", 32'(s_ready), 32'd1);
            s_valid = 1'b0;
         end else begin
            checkOutput("drain_s_ready",    32'(s_ready),    32'd0);
            checkOutput("drain_busy",       32'(busy),       32'd1);
            checkOutput("drain_done",       32'(done),       32'd0);
            checkOutput("drain_core_reset", 32'(core_reset), 32'd1);
            if (hold_valid) s_data = 32'hDEADBEEF;
            else s_valid = 1'b0;
         end
      end
      step();
      checkOutput("run_done",       32'(done),       32'd1);
      checkOutput("run_core_reset", 32'(core_reset), 32'd0);
      checkOutput("run_busy",       32'(busy),       32'd0);
      checkOutput("run_s_ready",    32'(s_ready),    32'd0);
      checkOutput("run_imem_we",    32'(imem_we),    32'd0);
      checkOutput("run_checksum",   checksum,        exp_sum);
      if (hold_valid) begin
         repeat (2) begin
            step();
            checkOutput("extra_word_we", 32'(imem_we), 32'd0);
         end
         s_valid = 1'b0;
      end
      checkOutput("write_count", 32'(write_count), 32'(len));
      for (int k = 0; k < len; k++) checkOutput("mem_contents", tb_mem[k], prog[k]);
   endtask

   initial begin
      reset   = 1'b0;
      start   = 1'b0;
      length  = '0;
      s_valid = 1'b0;
      s_data  = '0;

      #2 reset = 1'b1;
      #1 checkResetValues("async_reset");
      step();
      step();
      reset = 1'b0;
      step();
      checkResetValues("after_reset");
      s_valid = 1'b1;
      s_data  = $urandom;
      repeat (3) begin
         step();
         checkOutput("idle_s_ready", 32'(s_ready), 32'd0);
         checkOutput("idle_imem_we", 32'(imem_we), 32'd0);
      end
      s_valid = 1'b0;

      prog[0] = 32'h00000013;
      prog[1] = 32'h00500093;
      prog[2] = 32'h00a00113;
      applyStimulus(3, 0, 0, 1'b0);
      checkOutput("basic_checksum", checksum, 32'h00F001B9);

      for (int k = 0; k < 4; k++) prog[k] = $urandom;
      applyStimulus(4, 2, 2, 1'b0);

      repeat (4) begin
         int len;
         len = int'($urandom_range(16, 1));
         for (int k = 0; k < len; k++) prog[k] = $urandom;
         applyStimulus(len, 0, 3, 1'($urandom_range(1, 0)));
      end

      saved_sum = exp_sum;
      start  = 1'b1;
      length = 7'd0;
      step();
      start = 1'b0;
      checkOutput("err0_error",      32'(error),      32'd1);
      checkOutput("err0_s_ready",    32'(s_ready),    32'd0);
      checkOutput("err0_core_reset", 32'(core_reset), 32'd1);
      checkOutput("err0_done",       32'(done),       32'd0);
      checkOutput("err0_busy",       32'(busy),       32'd0);
      checkOutput("err0_checksum",   checksum,        saved_sum);
      s_valid = 1'b1;
      s_data  = $urandom;
      repeat (3) begin
         step();
         checkOutput("err_imem_we", 32'(imem_we), 32'd0);
         checkOutput("err_s_ready", 32'(s_ready), 32'd0);
      end
      s_valid = 1'b0;
      start   = 1'b1;
      length  = 7'd65;
      step();
      start = 1'b0;
      checkOutput("err65_error",    32'(error), 32'd1);
      checkOutput("err65_checksum", checksum,   saved_sum);
      start  = 1'b1;
      length = 7'($urandom_range(127, 66));
      step();
      start = 1'b0;
      checkOutput("errbig_error",   32'(error),   32'd1);
      checkOutput("errbig_s_ready", 32'(s_ready), 32'd0);
      prog[0] = $urandom;
      applyStimulus(1, 0, 2, 1'b0);

      for (int k = 0; k < DEPTH; k++) prog[k] = 32'(k);
      applyStimulus(DEPTH, 0, 0, 1'b1);
      checkOutput("full_checksum",  checksum,   32'd2016);
      checkOutput("full_last_addr", 32'(imem_addr), 32'd63);
      checkOutput("full_last_data", tb_mem[63], 32'd63);

      for (int k = 0; k < 4; k++) prog[k] = $urandom;
      start  = 1'b1;
      length = 7'd4;
      step();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s_valid = 1'b1;
         s_data  = prog[i];
         step();
         checkOutput("partial_addr", 32'(imem_addr), 32'(i));
         checkOutput("partial_data", imem_wdata,     prog[i]);
      end
      s_valid = 1'b0;
      #5 reset = 1'b1;
      #1 checkResetValues("mid_load_reset");
      step();
      reset = 1'b0;
      step();
      checkResetValues("post_mid_reset");

      for (int k = 0; k < 2; k++) prog[k] = $urandom;
      applyStimulus(2, 0, 1, 1'b0);
      for (int k = 0; k < 3; k++) prog[k] = $urandom;
      applyStimulus(3, 0, 1, 1'b0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
